// File: rtl/inst_decode_if.sv
// inst_decode_if -- handshake and decoded-field bundle for the RV32I decoder.
//
// Upstream side : in_valid, in_ready, inst, pc_in, flush
// Downstream side: out_valid, out_ready, opcode, funct3, funct7,
//                  rs1_addr, rs2_addr, rd_addr, imm, pc_out, illegal
//
// Modports:
//   slave  - the decoder itself (consumes instructions, produces fields)
//   master - the environment (fetch + execute side) driving the decoder
interface inst_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic [31:0]     imm;
  logic [XLEN-1:0] pc_out;
  logic            illegal;

  modport slave (
    input  in_valid, inst, pc_in, flush, out_ready,
    output in_ready, out_valid, opcode, funct3, funct7,
           rs1_addr, rs2_addr, rd_addr, imm, pc_out, illegal
  );

  modport master (
    output in_valid, inst, pc_in, flush, out_ready,
    input  in_ready, out_valid, opcode, funct3, funct7,
           rs1_addr, rs2_addr, rd_addr, imm, pc_out, illegal
  );
endinterface

// File: rtl/inst_decode.sv
// inst_decode -- RV32I instruction decoder with a two-entry skid buffer.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - inst_decode_if.slave: upstream valid/ready + inst/pc_in + flush,
//          downstream valid/ready + decoded fields, imm, pc_out, illegal
//
// Instructions are decoded as they are captured, so the storage holds
// decoded entries. The main register drives the outputs directly; the skid
// register catches one extra entry when downstream stalls, which lets
// in_ready be a registered signal.
//
// Configuration macro: INST_DECODE_ILLEGAL_CHECK_EN
//   defined   - illegal flags entries with a bad encoding (still passed on)
//   undefined - illegal is constant 0, no check logic is built
module inst_decode #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  inst_decode_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  // Immediate assembly by instruction format; U-type is not sign-extended.
  function automatic logic [31:0] decode_imm(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        r = {{20{i[31]}}, i[31:20]};
      7'b0100011:
        r = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:
        r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        r = {i[31:12], 12'h000};
      7'b1101111:
        r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        r = 32'h0000_0000;
    endcase
    return r;
  endfunction

`ifdef INST_DECODE_ILLEGAL_CHECK_EN
  // Flags non-32-bit encodings, unknown opcodes and R-type funct7 other
  // than the base ADD/SUB-style values.
  function automatic logic check_illegal(input logic [31:0] i);
    logic bad;
    if (i[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (i[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
        7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111:
          bad = 1'b0;
        7'b0110011:
          bad = (i[31:25] != 7'b0000000) && (i[31:25] != 7'b0100000);
        default:
          bad = 1'b1;
      endcase
    end
    return bad;
  endfunction
`endif

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  entry_t     main_r;
  entry_t     skid_r;
  entry_t     dec_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       accept_s;
  logic       drain_s;
  logic       load_main_dec_s;
  logic       load_main_skid_s;
  logic       load_skid_s;

  // Flush masks the upstream handshake in the same cycle it is raised.
  assign accept_s = bus.in_valid & in_ready_r & ~bus.flush;
  assign drain_s  = out_valid_r & bus.out_ready;

  // Field extraction of the incoming instruction at capture time.
  always_comb begin
    dec_s        = '0;
    dec_s.opcode = bus.inst[6:0];
    dec_s.rd     = bus.inst[11:7];
    dec_s.funct3 = bus.inst[14:12];
    dec_s.rs1    = bus.inst[19:15];
    dec_s.rs2    = bus.inst[24:20];
    dec_s.funct7 = bus.inst[31:25];
    dec_s.imm    = decode_imm(bus.inst);
    dec_s.pc     = bus.pc_in;
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
    dec_s.illegal = check_illegal(bus.inst);
`else
    dec_s.illegal = 1'b0;
`endif
  end

  // Occupancy FSM and register-load selects.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_dec_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (bus.flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s     = ST_ONE;
            load_main_dec_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            state_nxt_s     = ST_ONE;
            load_main_dec_s = 1'b1;
          end else if (accept_s) begin
            // Main is still held downstream; the newcomer waits in skid.
            state_nxt_s = ST_FULL;
            load_skid_s = 1'b1;
          end else if (drain_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_nxt_s      = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, handshake flags and entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      main_r      <= '0;
      skid_r      <= '0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      if (load_main_dec_s) begin
        main_r <= dec_s;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r & ~bus.flush;
  assign bus.out_valid = out_valid_r;
  assign bus.opcode    = main_r.opcode;
  assign bus.funct3    = main_r.funct3;
  assign bus.funct7    = main_r.funct7;
  assign bus.rs1_addr  = main_r.rs1;
  assign bus.rs2_addr  = main_r.rs2;
  assign bus.rd_addr   = main_r.rd;
  assign bus.imm       = main_r.imm;
  assign bus.pc_out    = main_r.pc;
  assign bus.illegal   = main_r.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode -- directed self-checking bench for inst_decode.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_inst_decode;

  localparam int XLEN = 32;
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  inst_decode_if #(.XLEN(XLEN)) bus ();

  inst_decode #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc);
    bus.in_valid = v;
    bus.inst     = i;
    bus.pc_in    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{32'h002081B3, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000, 1'b0};
    vecs[1] = '{32'hFFF00293, 7'h13, 5'd5,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{32'h0020A423, 7'h23, 5'd8,  5'd1,  5'd2,  3'd2, 7'h00, 32'h00000008, 1'b0};
    vecs[3] = '{32'hFE000CE3, 7'h63, 5'd25, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFF8, 1'b0};
    vecs[4] = '{32'h123450B7, 7'h37, 5'd1,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0};
    vecs[5] = '{32'hFFDFF06F, 7'h6F, 5'd0,  5'd31, 5'd29, 3'd7, 7'h7F, 32'hFFFFFFFC, 1'b0};
    vecs[6] = '{32'h00000000, 7'h00, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, ILL_EN};
    vecs[7] = '{32'h02208033, 7'h33, 5'd0,  5'd1,  5'd2,  3'd0, 7'h01, 32'h00000000, ILL_EN};

    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check_eq("rst_imm",       64'(bus.imm),       64'd0);
    check_eq("rst_pc_out",    64'(bus.pc_out),    64'd0);
    check_eq("rst_opcode",    64'(bus.opcode),    64'd0);
    check_eq("rst_illegal",   64'(bus.illegal),   64'd0);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check_eq("in_ready_after_edge", 64'(bus.in_ready), 64'd1);

    // Streaming decode with downstream always ready.
    bus.out_ready = 1'b1;
    drive(1'b1, vecs[0].inst, 32'h100);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("v%0d_valid", i),  64'(bus.out_valid), 64'd1);
      check_eq($sformatf("v%0d_opcode", i), 64'(bus.opcode),    64'(vecs[i].op));
      check_eq($sformatf("v%0d_rd", i),     64'(bus.rd_addr),   64'(vecs[i].rd));
      check_eq($sformatf("v%0d_rs1", i),    64'(bus.rs1_addr),  64'(vecs[i].rs1));
      check_eq($sformatf("v%0d_rs2", i),    64'(bus.rs2_addr),  64'(vecs[i].rs2));
      check_eq($sformatf("v%0d_funct3", i), 64'(bus.funct3),    64'(vecs[i].f3));
      check_eq($sformatf("v%0d_funct7", i), 64'(bus.funct7),    64'(vecs[i].f7));
      check_eq($sformatf("v%0d_imm", i),    64'(bus.imm),       64'(vecs[i].imm));
      check_eq($sformatf("v%0d_pc", i),     64'(bus.pc_out),    64'(32'h100 + 32'(4 * i)));
      check_eq($sformatf("v%0d_illegal", i), 64'(bus.illegal),  64'(vecs[i].ill));
      if (i < 7) drive(1'b1, vecs[i + 1].inst, 32'h100 + 32'(4 * (i + 1)));
      else       drive(1'b0, 32'h0, 32'h0);
    end
    @(negedge clk);
    check_eq("drain_empty_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure: fill both entries, third waits, order preserved.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h0);
    @(negedge clk);
    check_eq("bp1_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("bp1_pc",       64'(bus.pc_out),   64'h0);
    drive(1'b1, 32'h00000013, 32'h4);
    @(negedge clk);
    check_eq("bp2_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("bp2_pc",       64'(bus.pc_out),   64'h0);
    drive(1'b1, 32'h00000013, 32'h8);
    @(negedge clk);
    check_eq("bp3_in_ready", 64'(bus.in_ready),  64'd0);
    check_eq("bp3_valid",    64'(bus.out_valid), 64'd1);
    check_eq("bp3_pc_hold",  64'(bus.pc_out),    64'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp4_pc",       64'(bus.pc_out),   64'h4);
    check_eq("bp4_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check_eq("bp5_pc",    64'(bus.pc_out),    64'h8);
    check_eq("bp5_valid", 64'(bus.out_valid), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("bp6_valid", 64'(bus.out_valid), 64'd0);

    // Flush out of FULL, then flush masking in_ready.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h20);
    @(negedge clk);
    drive(1'b1, 32'h00000013, 32'h24);
    @(negedge clk);
    check_eq("fl_full_in_ready", 64'(bus.in_ready),  64'd0);
    check_eq("fl_full_valid",    64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("fl_valid_after", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h00000013, 32'h28);
    #1;
    check_eq("fl_in_ready_masked", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check_eq("fl_no_accept", 64'(bus.out_valid), 64'd0);
    bus.flush = 1'b0;
    #1;
    check_eq("fl_in_ready_back", 64'(bus.in_ready), 64'd1);

    // Asynchronous reset while one entry is held.
    @(negedge clk);
    check_eq("ar_one_valid", 64'(bus.out_valid), 64'd1);
    check_eq("ar_one_pc",    64'(bus.pc_out),    64'h28);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("ar_valid",    64'(bus.out_valid), 64'd0);
    check_eq("ar_in_ready", 64'(bus.in_ready),  64'd0);
    check_eq("ar_pc",       64'(bus.pc_out),    64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("ar_in_ready_pre", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check_eq("ar_in_ready_post", 64'(bus.in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
